// File: rtl/serializer_8x1_pkg.sv
// serializer_8x1_pkg: state encoding, word/select widths and parity helper shared by serializer_8x1.
package serializer_8x1_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Even parity: the emitted bit makes the total count of ones even.
    function automatic logic even_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/mux_8x1.sv
// mux_8x1: 8-to-1 single-bit multiplexer, y = I[{s2,s1,s0}].
module mux_8x1 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    input  logic i6,
    input  logic i7,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    output logic y
);

    logic [7:0] w_in;
    logic [2:0] w_s;

    assign w_in = {i7, i6, i5, i4, i3, i2, i1, i0};
    assign w_s  = {s2, s1, s0};
    assign y    = w_in[w_s];

endmodule

// File: rtl/serializer_8x1.sv
// serializer_8x1: 8-bit parallel-to-serial converter with valid/ready on both sides.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module serializer_8x1
    import serializer_8x1_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] din,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_out,
    output logic [SEL_W-1:0]  sel,
    output logic              last,
    output logic              busy
);

`ifdef SER_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_nxt;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic              w_accept;
    logic              w_hs;
    logic              w_bit;
    logic              w_final;

    mux_8x1 u_mux (
        .i0 (r_word[0]),
        .i1 (r_word[1]),
        .i2 (r_word[2]),
        .i3 (r_word[3]),
        .i4 (r_word[4]),
        .i5 (r_word[5]),
        .i6 (r_word[6]),
        .i7 (r_word[7]),
        .s0 (r_sel[0]),
        .s1 (r_sel[1]),
        .s2 (r_sel[2]),
        .y  (w_bit)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = ~in_ready;
    assign ser_valid = busy;
    assign sel       = r_sel;
    assign w_accept  = in_valid & in_ready;
    assign w_hs      = ser_valid & ser_ready;
    assign w_final   = (r_sel == SEL_W'(WORD_W - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_sel_nxt   = r_sel;
        ser_out     = IDLE_LEVEL;
        last        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_word_nxt  = din;
                    w_sel_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_out = w_bit;
                last    = w_final & ~PAR_EN;
                if (w_hs) begin
                    if (!w_final) begin
                        w_sel_nxt = r_sel + 1'b1;
                    end else if (PAR_EN) begin
                        // sel stays at 7 while the parity bit is on the wire
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_sel_nxt   = '0;
                    end
                end
            end
            ST_PARITY: begin
                ser_out = even_parity(r_word);
                last    = 1'b1;
                if (w_hs) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

endmodule

// File: tb/tb_serializer_8x1.sv
// tb_serializer_8x1: table vectors, hand-written corner sequences and a randomized
// all-256-words sweep against a bit-stream model; honours SER_PARITY_EN.
module tb_serializer_8x1;

    localparam logic IDLE_LVL = 1'b0;
`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_out;
    logic [2:0] sel;
    logic       last;
    logic       busy;

    int errors = 0;
    int checks = 0;

    serializer_8x1 #(.IDLE_LEVEL(IDLE_LVL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_out   (ser_out),
        .sel       (sel),
        .last      (last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] din;
        logic [7:0] bits;
        logic       par;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_ser_valid"}, 32'(ser_valid), 0);
        chk({tag, "_ser_out"}, 32'(ser_out), 32'(IDLE_LVL));
        chk({tag, "_sel"}, 32'(sel), 0);
        chk({tag, "_last"}, 32'(last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 60 && !in_ready; n++) tick();
        chk({tag, "_drain_timeout"}, 32'(in_ready), 1);
    endtask

    // Accept one word then stream it with ser_ready held high.
    task automatic send_word(input logic [7:0] d, input logic [7:0] eb, input logic ep);
        chk("accept_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        din      = d;
        tick();
        in_valid  = 1'b0;
        din       = 8'($urandom);
        ser_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            chk("word_ser_valid", 32'(ser_valid), 1);
            chk("word_sel", 32'(sel), (i < 8) ? i : 7);
            chk("word_ser_out", 32'(ser_out), (i < 8) ? 32'(eb[i]) : 32'(ep));
            chk("word_last", 32'(last), 32'(i == NB - 1));
            chk("word_in_ready", 32'(in_ready), 0);
            tick();
        end
        check_idle("word_end");
    endtask

    logic [7:0] got;
    logic [7:0] d;
    logic       stream[$];
    logic       model[$];
    int         cnt;

    initial begin
        tbl[0] = '{8'hA5, 8'b1010_0101, 1'b0};
        tbl[1] = '{8'h07, 8'b0000_0111, 1'b1};
        tbl[2] = '{8'hFF, 8'b1111_1111, 1'b0};
        tbl[3] = '{8'h00, 8'b0000_0000, 1'b0};
        tbl[4] = '{8'h01, 8'b0000_0001, 1'b1};
        tbl[5] = '{8'h80, 8'b1000_0000, 1'b1};
        tbl[6] = '{8'h3C, 8'b0011_1100, 1'b0};
        tbl[7] = '{8'h5A, 8'b0101_1010, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        ser_ready = 1'b0;
        din       = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

        for (int t = 0; t < 8; t++) send_word(tbl[t].din, tbl[t].bits, tbl[t].par);

        // Stall at sel=3 for three cycles, then resume.
        in_valid = 1'b1;
        din      = 8'hA5;
        tick();
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_sel", 32'(sel), 3);
            chk("stall_ser_out", 32'(ser_out), 0);
            chk("stall_last", 32'(last), 0);
            tick();
        end
        chk("stall_sel_after", 32'(sel), 3);
        ser_ready = 1'b1;
        tick();
        chk("resume_sel", 32'(sel), 4);
        chk("resume_ser_out", 32'(ser_out), 0);
        wait_idle("stall");

        // Reset in the middle of a word at sel=5.
        in_valid = 1'b1;
        din      = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_sel_pre", 32'(sel), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midrst");
        send_word(8'hFF, 8'hFF, 1'b0);

        // in_valid held with new din while busy must be ignored.
        in_valid = 1'b1;
        din      = 8'hFF;
        tick();
        din       = 8'h00;
        ser_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            chk("busy_ign_ser_out", 32'(ser_out), (i < 8) ? 1 : 0);
            chk("busy_ign_in_ready", 32'(in_ready), 0);
            tick();
        end
        chk("busy_ign_idle", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("second_busy", 32'(busy), 1);
        chk("second_sel", 32'(sel), 0);
        chk("second_ser_out", 32'(ser_out), 0);
        wait_idle("second");

        // All 256 words with random ready, random din/in_valid noise while busy.
        for (int n = 0; n < 256; n++) begin
            d = 8'(n);
            model.delete();
            stream.delete();
            for (int i = 0; i < 8; i++) model.push_back(1'((d >> i) & 8'h01));
            for (int i = 8; i < NB; i++) model.push_back(1'($countones(d) % 2));
            in_valid = 1'b0;
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            in_valid = 1'b1;
            din      = d;
            tick();
            cnt = 0;
            for (int c = 0; c < 200 && cnt < NB; c++) begin
                ser_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                din       = 8'($urandom);
                if (ser_valid && ser_ready) begin
                    chk("rnd_sel", 32'(sel), (cnt < 8) ? cnt : 7);
                    chk("rnd_last", 32'(last), 32'(cnt == NB - 1));
                    stream.push_back(ser_out);
                    cnt++;
                end
                tick();
            end
            in_valid = 1'b0;
            chk("rnd_count", 32'(cnt), 32'(NB));
            got = 8'h00;
            for (int i = 0; i < 8 && i < stream.size(); i++) got[i] = stream[i];
            chk("rnd_reassembled", 32'(got), 32'(d));
            for (int i = 0; i < NB && i < stream.size(); i++)
                chk("rnd_stream", 32'(stream[i]), 32'(model[i]));
            chk("rnd_end_idle", 32'(in_ready), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serializer_8x1.md
SERIALIZER_8X1 -- requirements
Module: serializer_8x1

Interface
REQ-001 Parameter: IDLE_LEVEL, default 1'b0, ser_out value whenever ser_valid=0.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: in_valid  in  1  upstream offers din.
REQ-005 Port: in_ready  out  1  block can accept a word.
REQ-006 Port: din  in  8  parallel word; din[0] is I0 … din[7] is I7.
REQ-007 Port: ser_valid  out  1  ser_out carries a valid bit.
REQ-008 Port: ser_ready  in  1  downstream accepts current bit.
REQ-009 Port: ser_out  out  1  serial data bit.
REQ-010 Port: sel  out  3  current bit index {s2,s1,s0}.
REQ-011 Port: last  out  1  ser_out is the final bit of the word.
REQ-012 Port: busy  out  1  word in progress (state != IDLE).

Function
REQ-013 States: IDLE, SHIFT, PARITY (PARITY exists only per REQ-026).
REQ-014 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready at a rising edge.
REQ-015 On accept: din latched into 8-bit word register, sel<=0, state<=SHIFT; ser_valid=1 from the next cycle.
REQ-016 In SHIFT: ser_out SHALL equal word[sel], selected through the 8:1 mux combinationally from registered word and sel.
REQ-017 Bit handshake = ser_valid & ser_ready at a rising edge; on handshake with sel<7, sel<=sel+1.
REQ-018 Without handshake (ser_ready=0): sel, word, ser_out, last held unchanged indefinitely.
REQ-019 On handshake with sel==7: state<=PARITY if enabled, else IDLE; sel wraps to 0.
REQ-020 last=1 on the final bit only (sel==7 in SHIFT without parity; PARITY state with parity).
REQ-021 in_valid while busy SHALL be ignored; din changes while busy SHALL NOT affect output.
REQ-022 Minimum word period: 1 accept cycle + 8 bit cycles (+1 parity); no back-to-back accept on the final-bit cycle.
REQ-023 ser_valid=0 in IDLE; ser_out=IDLE_LEVEL, sel=0, last=0 in IDLE.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, word=0, sel=0; outputs next cycle: in_ready=1, ser_valid=0, ser_out=IDLE_LEVEL, last=0, busy=0.
REQ-025 rst SHALL take priority over accept and handshake; a word in progress is discarded, no further bits emitted.

Configuration
REQ-026 Macro SER_PARITY_EN: defined -> after bit 7 handshake, PARITY state emits ser_out = XOR of word[7:0] (even parity), sel held at 7, last=1, handshake returns to IDLE; undefined -> no PARITY state, 8 bits per word.

Structure
REQ-027 Shared package SHALL hold state encoding (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2) and WORD_W=8, SEL_W=3 constants.
REQ-028 One sub-module: existing mux_8x1 instantiated with word bits as I0..I7, sel as s0..s2, output as SHIFT-state data bit.

Verification
REQ-029 rst, then din=8'hA5, in_valid=1 one cycle, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1 on sel 0..7, last only at sel=7, IDLE after.
REQ-030 SER_PARITY_EN defined, din=8'h07 -> 8 data bits 1,1,1,0,0,0,0,0 then parity bit 1 with last=1; din=8'hA5 -> parity 0.
REQ-031 ser_ready=0 for 3 cycles at sel=3 (din=8'hA5) -> sel=3, ser_out=0 held; resumes with sel=4 after ser_ready=1.
REQ-032 rst asserted at sel=5 -> next cycle in_ready=1, ser_valid=0, sel=0; new word 8'hFF then serialized from bit 0.
REQ-033 in_valid=1 with din=8'h00 while busy on 8'hFF -> all 8 bits 1, second word accepted only after return to IDLE.
REQ-034 Exhaustive: all 256 din values, ser_ready randomly toggled -> reassembled word equals din every time.
